// File: rtl/bus_fabric.sv
// Address-decode fabric: dual-lane CPU port to NREGIONS ascending regions,
// with per-region read wait states, ready stall and sticky unmapped-error capture.
module bus_fabric #(
  parameter int ADDRBITS = 15,
  parameter int NREGIONS = 4,
  parameter logic [NREGIONS*ADDRBITS-1:0] REGION_BASE =
    {15'h1000, 15'h0800, 15'h0040, 15'h0000},
  parameter logic [NREGIONS*4-1:0] REGION_WAIT =
    {4'd0, 4'd0, 4'd2, 4'd0}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDRBITS-1:0]   read_addr_even,
  input  logic                  read_en_even,
  input  logic [ADDRBITS-1:0]   write_addr_even,
  input  logic                  write_en_even,
  output logic [NREGIONS-1:0]   region_write_en_even,
  input  logic [NREGIONS*8-1:0] region_read_data_even,
  output logic [7:0]            read_data_even,
  input  logic [ADDRBITS-1:0]   read_addr_odd,
  input  logic                  read_en_odd,
  input  logic [ADDRBITS-1:0]   write_addr_odd,
  input  logic                  write_en_odd,
  output logic [NREGIONS-1:0]   region_write_en_odd,
  input  logic [NREGIONS*8-1:0] region_read_data_odd,
  output logic [7:0]            read_data_odd,
  output logic                  ready,
  output logic                  bus_error,
  output logic [ADDRBITS-1:0]   error_addr,
  input  logic                  error_clear
);

  localparam int IW = $clog2(NREGIONS);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  // Decode result: {hit, region index}; bases ascend so the last match wins
  function automatic logic [IW:0] f_decode(
    input logic [ADDRBITS-1:0] a
  );
    logic [IW:0] r;
    r = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (a >= REGION_BASE[i*ADDRBITS +: ADDRBITS])
        r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [IW:0]   r_sel_e;
  logic [IW:0]   r_sel_o;
  logic          r_bus_error;
  logic [ADDRBITS-1:0] r_error_addr;

  logic [IW:0]   w_rd_e;
  logic [IW:0]   w_rd_o;
  logic [IW:0]   w_wr_e;
  logic [IW:0]   w_wr_o;
  logic [3:0]    w_wait_e;
  logic [3:0]    w_wait_o;
  logic [3:0]    w_wait;
  logic          w_ready;
  logic          w_capture;
  logic          w_err_re;
  logic          w_err_ro;
  logic          w_err_we;
  logic          w_err_wo;
  logic          w_err;
  logic [ADDRBITS-1:0] w_err_addr;

  assign w_rd_e = f_decode(read_addr_even);
  assign w_rd_o = f_decode(read_addr_odd);
  assign w_wr_e = f_decode(write_addr_even);
  assign w_wr_o = f_decode(write_addr_odd);

  assign w_wait_e = (read_en_even && w_rd_e[IW]) ?
    REGION_WAIT[w_rd_e[IW-1:0]*4 +: 4] : 4'd0;
  assign w_wait_o = (read_en_odd && w_rd_o[IW]) ?
    REGION_WAIT[w_rd_o[IW-1:0]*4 +: 4] : 4'd0;
  assign w_wait = (w_wait_e > w_wait_o) ? w_wait_e : w_wait_o;

  assign w_ready   = (r_state == ST_RUN);
  assign w_capture = w_ready && (read_en_even || read_en_odd);
  assign ready     = w_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_capture && (w_wait != 4'd0)) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = w_wait;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_e <= '0;
      r_sel_o <= '0;
    end else if (w_capture) begin
      if (read_en_even) r_sel_e <= w_rd_e;
      if (read_en_odd)  r_sel_o <= w_rd_o;
    end
  end

  assign read_data_even = r_sel_e[IW] ?
    region_read_data_even[r_sel_e[IW-1:0]*8 +: 8] : 8'hFF;
  assign read_data_odd = r_sel_o[IW] ?
    region_read_data_odd[r_sel_o[IW-1:0]*8 +: 8] : 8'hFF;

  // Gated by reset_n so an aborted access never strobes a target
  always_comb begin
    region_write_en_even = '0;
    region_write_en_odd  = '0;
    if (write_en_even && w_wr_e[IW] && w_ready && reset_n)
      region_write_en_even[w_wr_e[IW-1:0]] = 1'b1;
    if (write_en_odd && w_wr_o[IW] && w_ready && reset_n)
      region_write_en_odd[w_wr_o[IW-1:0]] = 1'b1;
  end

  assign w_err_re = w_capture && read_en_even && !w_rd_e[IW];
  assign w_err_ro = w_capture && read_en_odd && !w_rd_o[IW];
  assign w_err_we = w_ready && write_en_even && !w_wr_e[IW];
  assign w_err_wo = w_ready && write_en_odd && !w_wr_o[IW];
  assign w_err = w_err_re || w_err_ro || w_err_we || w_err_wo;

  always_comb begin
    w_err_addr = '0;
    if (w_err_re)      w_err_addr = read_addr_even;
    else if (w_err_ro) w_err_addr = read_addr_odd;
    else if (w_err_we) w_err_addr = write_addr_even;
    else if (w_err_wo) w_err_addr = write_addr_odd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_error  <= 1'b0;
      r_error_addr <= '0;
    end else if (w_err && (!r_bus_error || error_clear)) begin
      r_bus_error  <= 1'b1;
      r_error_addr <= w_err_addr;
    end else if (error_clear) begin
      r_bus_error  <= 1'b0;
      r_error_addr <= '0;
    end
  end

  assign bus_error  = r_bus_error;
  assign error_addr = r_error_addr;

endmodule

// File: tb/tb_bus_fabric.sv
// Bench for bus_fabric: directed vector table, reset-abort sequence
// and randomized traffic against a transaction-level reference model.
module tb_bus_fabric;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] ra_e, wa_e, ra_o, wa_o;
  logic        re_e, we_e, re_o, we_o, clr;
  logic [3:0]  rwe_e, rwe_o;
  logic [31:0] rdd_e, rdd_o;
  logic [7:0]  rd_e, rd_o;
  logic        rdy, berr;
  logic [14:0] eaddr;

  int n_chk = 0;
  int n_fail = 0;

  bus_fabric #(
    .ADDRBITS(15),
    .NREGIONS(4),
    .REGION_BASE({15'h1000, 15'h0800, 15'h0040, 15'h0010}),
    .REGION_WAIT({4'd0, 4'd0, 4'd2, 4'd0})
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .read_addr_even(ra_e), .read_en_even(re_e),
    .write_addr_even(wa_e), .write_en_even(we_e),
    .region_write_en_even(rwe_e),
    .region_read_data_even(rdd_e),
    .read_data_even(rd_e),
    .read_addr_odd(ra_o), .read_en_odd(re_o),
    .write_addr_odd(wa_o), .write_en_odd(we_o),
    .region_write_en_odd(rwe_o),
    .region_read_data_odd(rdd_o),
    .read_data_odd(rd_o),
    .ready(rdy), .bus_error(berr),
    .error_addr(eaddr), .error_clear(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic re_e; logic [14:0] ra_e;
    logic re_o; logic [14:0] ra_o;
    logic we_e; logic [14:0] wa_e;
    logic we_o; logic [14:0] wa_o;
    logic clr;
    logic x_rdy;
    logic [7:0] x_rd_e; logic [7:0] x_rd_o;
    logic [3:0] x_we_e; logic [3:0] x_we_o;
    logic x_err; logic [14:0] x_ea;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic a_re_e, input logic [14:0] a_ra_e,
    input logic a_re_o, input logic [14:0] a_ra_o,
    input logic a_we_e, input logic [14:0] a_wa_e,
    input logic a_we_o, input logic [14:0] a_wa_o,
    input logic a_clr, input logic a_rdy,
    input logic [7:0] a_rde, input logic [7:0] a_rdo,
    input logic [3:0] a_wee, input logic [3:0] a_weo,
    input logic a_err, input logic [14:0] a_ea);
    vec_t v;
    v.re_e = a_re_e; v.ra_e = a_ra_e;
    v.re_o = a_re_o; v.ra_o = a_ra_o;
    v.we_e = a_we_e; v.wa_e = a_wa_e;
    v.we_o = a_we_o; v.wa_o = a_wa_o;
    v.clr = a_clr; v.x_rdy = a_rdy;
    v.x_rd_e = a_rde; v.x_rd_o = a_rdo;
    v.x_we_e = a_wee; v.x_we_o = a_weo;
    v.x_err = a_err; v.x_ea = a_ea;
    vq.push_back(v);
  endtask

  task automatic build_table();
    // re_e ra_e  re_o ra_o  we_e wa_e  we_o wa_o  clr | rdy rd_e rd_o we_e we_o err ea
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'hFF,8'hFF,0,0,0,0);
    add(1,'h1005, 0,0,      0,0,      0,0,      0, 1,8'hFF,8'hFF,0,0,0,0);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'hA5,8'hFF,0,0,0,0);
    add(1,'h0100, 1,'h1000, 0,0,      0,0,      0, 1,8'hA5,8'hFF,0,0,0,0);
    add(1,'h0100, 1,'h1000, 0,0,      1,'h0800, 0, 0,8'h22,8'h5A,0,0,0,0);
    add(1,'h0100, 1,'h1000, 0,0,      1,'h0800, 0, 0,8'h22,8'h5A,0,0,0,0);
    add(0,0,      0,0,      0,0,      1,'h0800, 0, 1,8'h22,8'h5A,0,4'b0100,0,0);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'h22,8'h5A,0,0,0,0);
    add(1,'h0003, 1,'h0004, 0,0,      0,0,      0, 1,8'h22,8'h5A,0,0,0,0);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'hFF,8'hFF,0,0,1,'h0003);
    add(0,0,      0,0,      1,'h0005, 0,0,      0, 1,8'hFF,8'hFF,0,0,1,'h0003);
    add(0,0,      0,0,      0,0,      1,'h0007, 1, 1,8'hFF,8'hFF,0,0,1,'h0003);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'hFF,8'hFF,0,0,1,'h0007);
    add(0,0,      0,0,      0,0,      0,0,      1, 1,8'hFF,8'hFF,0,0,1,'h0007);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'hFF,8'hFF,0,0,0,0);
    add(0,0,      0,0,      1,'h0040, 1,'h003F, 0, 1,8'hFF,8'hFF,4'b0010,4'b0001,0,0);
    add(1,'h0800, 1,'h07FF, 0,0,      0,0,      0, 1,8'hFF,8'hFF,0,0,0,0);
    add(1,'h0800, 1,'h07FF, 0,0,      0,0,      0, 0,8'h33,8'h55,0,0,0,0);
    add(1,'h0800, 1,'h07FF, 0,0,      0,0,      0, 0,8'h33,8'h55,0,0,0,0);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'h33,8'h55,0,0,0,0);
    add(0,0,      1,'h0010, 0,0,      0,0,      0, 1,8'h33,8'h55,0,0,0,0);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'h33,8'h66,0,0,0,0);
    add(1,'h0FFF, 1,'h000F, 0,0,      0,0,      0, 1,8'h33,8'h66,0,0,0,0);
    add(0,0,      0,0,      0,0,      0,0,      0, 1,8'h33,8'hFF,0,0,1,'h000F);
  endtask

  // ---------------- reference model ----------------
  int m_base[4] = '{'h0010, 'h0040, 'h0800, 'h1000};
  int m_wait[4] = '{0, 2, 0, 0};
  int m_stall, m_sel_e, m_sel_o;
  logic m_err;
  logic [14:0] m_ea;

  function automatic int region(input logic [14:0] a);
    int r = -1;
    for (int i = 0; i < 4; i++)
      if (int'(a) >= m_base[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] pick(input logic [31:0] d,
                                      input int s);
    if (s < 0) return 8'hFF;
    return d[s*8 +: 8];
  endfunction

  function automatic logic [3:0] wen(input logic en,
                                     input logic [14:0] a);
    int r = region(a);
    if (!en || m_stall != 0 || r < 0) return 4'b0000;
    return 4'b0001 << r;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_sel_e = -1; m_sel_o = -1;
    m_err = 1'b0; m_ea = '0;
  endtask

  task automatic model_step();
    bit ok = (m_stall == 0);
    bit cap = ok && (re_e || re_o);
    bit e = 1'b0;
    logic [14:0] ea = '0;
    int w = 0;
    if (cap && re_e && region(ra_e) < 0) begin e = 1; ea = ra_e; end
    else if (cap && re_o && region(ra_o) < 0) begin e = 1; ea = ra_o; end
    else if (ok && we_e && region(wa_e) < 0) begin e = 1; ea = wa_e; end
    else if (ok && we_o && region(wa_o) < 0) begin e = 1; ea = wa_o; end
    if (e && (!m_err || clr)) begin m_err = 1; m_ea = ea; end
    else if (clr) begin m_err = 0; m_ea = '0; end
    if (cap) begin
      if (re_e) begin
        m_sel_e = region(ra_e);
        if (m_sel_e >= 0 && m_wait[m_sel_e] > w) w = m_wait[m_sel_e];
      end
      if (re_o) begin
        m_sel_o = region(ra_o);
        if (m_sel_o >= 0 && m_wait[m_sel_o] > w) w = m_wait[m_sel_o];
      end
      m_stall = w;
    end else if (!ok) begin
      m_stall--;
    end
  endtask

  function automatic logic [14:0] rnd_addr();
    int k;
    unique case ($urandom_range(0, 4))
      0: return 15'($urandom_range(0, 'h1F));
      1: begin
        k = $urandom_range(0, 3);
        return 15'(m_base[k] + $urandom_range(0, 2) - 1);
      end
      2: return 15'($urandom_range(0, 'h7FFF));
      default: return 15'($urandom_range(0, 'h17FF));
    endcase
  endfunction

  task automatic clear_inputs();
    re_e = 0; re_o = 0; we_e = 0; we_o = 0; clr = 0;
    ra_e = '0; ra_o = '0; wa_e = '0; wa_o = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    rdd_e = 32'hA5_33_22_11;
    rdd_o = 32'h5A_44_55_66;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    build_table();
    foreach (vq[i]) begin
      re_e = vq[i].re_e; ra_e = vq[i].ra_e;
      re_o = vq[i].re_o; ra_o = vq[i].ra_o;
      we_e = vq[i].we_e; wa_e = vq[i].wa_e;
      we_o = vq[i].we_o; wa_o = vq[i].wa_o;
      clr = vq[i].clr;
      #3;
      chk($sformatf("v%0d.ready", i), 32'(rdy), 32'(vq[i].x_rdy));
      chk($sformatf("v%0d.rd_e", i), 32'(rd_e), 32'(vq[i].x_rd_e));
      chk($sformatf("v%0d.rd_o", i), 32'(rd_o), 32'(vq[i].x_rd_o));
      chk($sformatf("v%0d.we_e", i), 32'(rwe_e), 32'(vq[i].x_we_e));
      chk($sformatf("v%0d.we_o", i), 32'(rwe_o), 32'(vq[i].x_we_o));
      chk($sformatf("v%0d.err", i), 32'(berr), 32'(vq[i].x_err));
      chk($sformatf("v%0d.eaddr", i), 32'(eaddr), 32'(vq[i].x_ea));
      @(posedge clk); #1;
    end

    // Reset arriving mid-WAIT with a held write
    clear_inputs();
    re_e = 1; ra_e = 15'h0100;
    @(posedge clk); #1;
    we_e = 1; wa_e = 15'h1000;
    #1;
    chk("rst.pre_ready", 32'(rdy), 32'd0);
    chk("rst.pre_we", 32'(rwe_e), 32'd0);
    chk("rst.pre_err", 32'(berr), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.ready", 32'(rdy), 32'd1);
    chk("rst.rd_e", 32'(rd_e), 32'hFF);
    chk("rst.rd_o", 32'(rd_o), 32'hFF);
    chk("rst.err", 32'(berr), 32'd0);
    chk("rst.eaddr", 32'(eaddr), 32'd0);
    chk("rst.we_e", 32'(rwe_e), 32'd0);
    chk("rst.we_o", 32'(rwe_o), 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic; request inputs are held during stalls
    for (int c = 0; c < 800; c++) begin
      rdd_e = $urandom; rdd_o = $urandom;
      clr = ($urandom_range(0, 15) == 0);
      if (m_stall == 0) begin
        re_e = ($urandom_range(0, 2) == 0); ra_e = rnd_addr();
        re_o = ($urandom_range(0, 2) == 0); ra_o = rnd_addr();
        we_e = ($urandom_range(0, 2) == 0); wa_e = rnd_addr();
        we_o = ($urandom_range(0, 2) == 0); wa_o = rnd_addr();
      end
      #3;
      chk($sformatf("r%0d.ready", c), 32'(rdy), 32'(m_stall == 0));
      chk($sformatf("r%0d.rd_e", c), 32'(rd_e), 32'(pick(rdd_e, m_sel_e)));
      chk($sformatf("r%0d.rd_o", c), 32'(rd_o), 32'(pick(rdd_o, m_sel_o)));
      chk($sformatf("r%0d.we_e", c), 32'(rwe_e), 32'(wen(we_e, wa_e)));
      chk($sformatf("r%0d.we_o", c), 32'(rwe_o), 32'(wen(we_o, wa_o)));
      chk($sformatf("r%0d.err", c), 32'(berr), 32'(m_err));
      chk($sformatf("r%0d.eaddr", c), 32'(eaddr), 32'(m_ea));
      model_step();
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
